// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-lane data memory.
package dmem_pkg;

  // Load width/sign codes (funct3 of RV32I loads)
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Store width codes (funct3 of RV32I stores)
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  // Controller states: post-reset clear sweep, then normal service
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int unsigned DMEM_DEPTH_DEF  = 256;
  localparam int unsigned WORD_IDX_W_DEF  = $clog2(DMEM_DEPTH_DEF);

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select plus sign/zero extension.
// Halfword selects on off_i[1] only and word ignores off_i, so a misaligned
// access that reaches here is implicitly forced to alignment.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane(s) and extend to 32 bits
  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Parametrised RV32I data memory with byte-lane stores, registered
// sign/zero-extended loads and a post-reset clear sequencer.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misaligned accesses flagged
// as errors instead of being forced to alignment).
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic              misalign;
  logic              st_ok, ld_ok;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  assign accept   = req_i && (state_q == IDLE);
  assign idx      = addr_i[IDX_W+1:2];
  assign off      = addr_i[1:0];
  assign rd_word  = mem_q[idx];

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == CLEAR);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Address bits above the word index are intentionally ignored (wrap)
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];
  end

`ifdef DMEM_MISALIGN_ERR_EN
  // Flag halfword/word accesses that are not naturally aligned
  always_comb begin
    misalign = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misalign = off[0];
      2'b10:   misalign = (off != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Legal funct3 decode for loads and stores
  always_comb begin
    st_ok = 1'b0;
    ld_ok = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: begin
        st_ok = ~misalign;
        ld_ok = ~misalign;
      end
      3'b100, 3'b101: ld_ok = ~misalign;
      default: ;
    endcase
  end

  // Store byte-lane enables and lane-replicated write data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_i;
    case (funct3_i)
      F3_SB: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{wdata_i[7:0]}};
      end
      F3_SH: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_i;
      end
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (accept && we_i && st_ok) begin
      mem_we    = 1'b1;
      mem_widx  = idx;
      mem_be    = st_be;
      mem_wdata = st_wdata;
    end
  end

  dmem_load_align u_load_align (
    .word_i   (rd_word),
    .off_i    (off),
    .funct3_i (funct3_i),
    .data_o   (ld_data)
  );

  // Next-state, clear counter and registered response generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (we_i) begin
            err_d = ~st_ok;
          end else begin
            rvalid_d = 1'b1;
            err_d    = ~ld_ok;
            rdata_d  = ld_ok ? ld_data : '0;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array, byte-lane write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (mem_be[l]) mem_q[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench for dmem_bytelane (DEPTH = 16).
module tb_dmem_bytelane;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  dmem_bytelane #(.DEPTH(16), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .we_i     (we_i),
    .funct3_i (funct3_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i    = r;
    we_i     = w;
    funct3_i = f3;
    addr_i   = a;
    wdata_i  = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (3) tick();

    check("rst_busy",   busy_o,   1);
    check("rst_ready",  ready_o,  0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata",  rdata_o,  32'h0);
    check("rst_err",    err_o,    0);

    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("clr_busy",  busy_o,  1);
      check("clr_ready", ready_o, 0);
      tick();
    end
    check("clr_done_ready", ready_o, 1);
    check("clr_done_busy",  busy_o,  0);

    // LW of the last word returns cleared data
    drive(1'b1, 1'b0, 3'b010, 32'h3C, 32'h0); tick(); idle();
    check("lw3c_rvalid", rvalid_o, 1);
    check("lw3c_rdata",  rdata_o,  32'h0);
    check("lw3c_err",    err_o,    0);
    tick();
    check("lw3c_pulse", rvalid_o, 0);

    // SW then back-to-back sub-word loads
    drive(1'b1, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF); tick();
    check("sw8_rvalid", rvalid_o, 0);
    check("sw8_err",    err_o,    0);
    drive(1'b1, 1'b0, 3'b000, 32'h09, 32'h0); tick();
    check("lb9_rvalid", rvalid_o, 1);
    check("lb9_rdata",  rdata_o,  32'hFFFFFFBE);
    drive(1'b1, 1'b0, 3'b100, 32'h09, 32'h0); tick();
    check("lbu9_rdata", rdata_o,  32'h000000BE);
    drive(1'b1, 1'b0, 3'b001, 32'h0A, 32'h0); tick();
    check("lha_rdata",  rdata_o,  32'hFFFFDEAD);
    drive(1'b1, 1'b0, 3'b101, 32'h0A, 32'h0); tick(); idle();
    check("lhua_rdata", rdata_o,  32'h0000DEAD);
    tick();
    check("hold_rvalid", rvalid_o, 0);
    check("hold_rdata",  rdata_o,  32'h0000DEAD);

    // Store, byte store, load on consecutive cycles
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344); tick();
    drive(1'b1, 1'b1, 3'b000, 32'h12, 32'h000000AA); tick();
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); tick(); idle();
    check("b2b_rvalid", rvalid_o, 1);
    check("b2b_rdata",  rdata_o,  32'h11AA3344);

    // Address wrap modulo DEPTH*4
    drive(1'b1, 1'b1, 3'b010, 32'h00, 32'h55667788); tick();
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); tick();
    check("wrap40_rdata", rdata_o, 32'h55667788);
    drive(1'b1, 1'b0, 3'b010, 32'h00, 32'h0); tick(); idle();
    check("wrap00_rdata", rdata_o, 32'h55667788);

    // Illegal load funct3
    drive(1'b1, 1'b0, 3'b011, 32'h08, 32'h0); tick(); idle();
    check("illld_err",    err_o,    1);
    check("illld_rvalid", rvalid_o, 1);
    check("illld_rdata",  rdata_o,  32'h0);
    tick();
    check("illld_err_pulse", err_o, 0);

    // Illegal store funct3 leaves memory untouched
    drive(1'b1, 1'b1, 3'b011, 32'h08, 32'hFFFFFFFF); tick(); idle();
    check("illst_err",    err_o,    1);
    check("illst_rvalid", rvalid_o, 0);
    drive(1'b1, 1'b0, 3'b010, 32'h08, 32'h0); tick(); idle();
    check("illst_mem8", rdata_o, 32'hDEADBEEF);
    check("illst_lw_err", err_o, 0);
    drive(1'b1, 1'b1, 3'b110, 32'h10, 32'h0); tick();
    check("illst110_err", err_o, 1);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); tick(); idle();
    check("illst110_mem", rdata_o, 32'h11AA3344);

    // Misaligned halfword store / load at 0x5
    drive(1'b1, 1'b1, 3'b001, 32'h05, 32'h0000CAFE); tick(); idle();
`ifdef DMEM_MISALIGN_ERR_EN
    check("sh5_err", err_o, 1);
`else
    check("sh5_err", err_o, 0);
`endif
    drive(1'b1, 1'b0, 3'b010, 32'h04, 32'h0); tick();
`ifdef DMEM_MISALIGN_ERR_EN
    check("sh5_mem", rdata_o, 32'h00000000);
`else
    check("sh5_mem", rdata_o, 32'h0000CAFE);
`endif
    drive(1'b1, 1'b0, 3'b001, 32'h05, 32'h0); tick(); idle();
`ifdef DMEM_MISALIGN_ERR_EN
    check("lh5_err",   err_o,   1);
    check("lh5_rdata", rdata_o, 32'h0);
`else
    check("lh5_err",   err_o,   0);
    check("lh5_rdata", rdata_o, 32'h0000CAFE ^ 32'hFFFF0000);
`endif

    // Reset clears response registers
    reset = 1'b0;
    tick();
    check("rst2_rdata", rdata_o, 32'h0);
    check("rst2_busy",  busy_o,  1);
    reset = 1'b1;

    // Reset again at cycle 5 of the clear, with a pending load held high
    repeat (5) tick();
    check("mid_busy", busy_o, 1);
    drive(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy",   busy_o,   1);
    check("midrst_ready",  ready_o,  0);
    check("midrst_rvalid", rvalid_o, 0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("reclr_busy",   busy_o,   1);
      check("reclr_rvalid", rvalid_o, 0);
      tick();
    end
    idle();
    check("reclr_ready",  ready_o,  1);
    check("reclr_rvalid2", rvalid_o, 0);

    // Second clear wiped earlier contents
    drive(1'b1, 1'b0, 3'b010, 32'h08, 32'h0); tick(); idle();
    check("reclr_rvalid3", rvalid_o, 1);
    check("reclr_mem8",    rdata_o,  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
